// File: rtl/module_relu_pool_pkg.sv
// Shared widths, saturation constant and arithmetic helpers for the ReLU/requantise/2x2 max-pool block.
`default_nettype none
package module_relu_pool_pkg;
   localparam int ACC_W = 18;
   localparam int PIX_W = 8;
   localparam logic [PIX_W-1:0] SAT_MAX = 8'd255;

   // ReLU, round-half-up right shift, then clamp to the unsigned pixel range.
   function automatic logic [PIX_W-1:0] requant(input logic signed [ACC_W:0] sum,
                                                input logic [ACC_W:0] rnd,
                                                input int shift);
      logic [ACC_W:0] t;
      t = ($unsigned(sum) + rnd) >> shift;
      if (sum[ACC_W])
         requant = '0;
      else if (|t[ACC_W:PIX_W])
         requant = SAT_MAX;
      else
         requant = t[PIX_W-1:0];
   endfunction

   function automatic logic [PIX_W-1:0] pix_max(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
      pix_max = (a > b) ? a : b;
   endfunction
endpackage
`default_nettype wire

// File: rtl/module_relu_pool_line_buffer.sv
// Simple dual-port line buffer holding one row of horizontal maxima; synchronous 1-cycle read.
`default_nettype none
module pool_line_buffer #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end
endmodule
`default_nettype wire

// File: rtl/module_relu_pool.sv
// Bias add, ReLU, requantisation and 2x2 max pooling over a raster-ordered frame.
`default_nettype none
module module_relu_pool
   import module_relu_pool_pkg::*;
#(
   parameter int COL_NUM = 128,
   parameter int ROW_NUM = 128,
   parameter int SHIFT   = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    valid_in,
   input  logic signed [ACC_W-1:0] din,
   input  logic signed [ACC_W-1:0] bias,
   output logic                    valid_out,
   output logic [PIX_W-1:0]        dout,
   output logic                    frame_done
);
   localparam int COL_W = $clog2(COL_NUM);
   localparam int ROW_W = $clog2(ROW_NUM);
   localparam int AW    = COL_W - 1;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(COL_NUM - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROW_NUM - 1);
   localparam logic [ACC_W:0]   RND      = (ACC_W+1)'((1 << SHIFT) >> 1);

   logic [COL_W-1:0]        col_cnt;
   logic [ROW_W-1:0]        row_cnt;
   logic signed [ACC_W-1:0] bias_r;

   logic                    s1_valid, s1_col_odd, s1_row_odd, s1_last;
   logic signed [ACC_W:0]   s1_sum;
   logic [AW-1:0]           s1_addr;

   logic [PIX_W-1:0]        even_q;
   logic                    s2_valid, s2_row_odd, s2_last;
   logic [PIX_W-1:0]        s2_hmax;
   logic [AW-1:0]           s2_addr;

   logic [PIX_W-1:0]        lb_rd_data;
   logic                    first_beat, last_col, last_row;
   logic signed [ACC_W-1:0] bias_sel;
   logic [PIX_W-1:0]        q, hmax;

   assign last_col   = (col_cnt == LAST_COL);
   assign last_row   = (row_cnt == LAST_ROW);
   assign first_beat = (col_cnt == '0) && (row_cnt == '0);
   // The frame's first beat must already see its own bias.
   assign bias_sel   = first_beat ? bias : bias_r;
   assign q          = requant(s1_sum, RND, SHIFT);
   assign hmax       = pix_max(even_q, q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_cnt    <= '0;
         row_cnt    <= '0;
         bias_r     <= '0;
         s1_valid   <= 1'b0;
         s1_sum     <= '0;
         s1_col_odd <= 1'b0;
         s1_row_odd <= 1'b0;
         s1_addr    <= '0;
         s1_last    <= 1'b0;
      end else begin
         s1_valid <= valid_in;
         if (valid_in) begin
            s1_sum     <= {din[ACC_W-1], din} + {bias_sel[ACC_W-1], bias_sel};
            s1_col_odd <= col_cnt[0];
            s1_row_odd <= row_cnt[0];
            s1_addr    <= col_cnt[COL_W-1:1];
            s1_last    <= last_col && last_row;
            if (first_beat)
               bias_r <= bias;
            if (last_col) begin
               col_cnt <= '0;
               row_cnt <= last_row ? '0 : row_cnt + 1'b1;
            end else begin
               col_cnt <= col_cnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         even_q     <= '0;
         s2_valid   <= 1'b0;
         s2_hmax    <= '0;
         s2_row_odd <= 1'b0;
         s2_addr    <= '0;
         s2_last    <= 1'b0;
      end else begin
         s2_valid <= s1_valid && s1_col_odd;
         if (s1_valid && !s1_col_odd)
            even_q <= q;
         if (s1_valid && s1_col_odd) begin
            s2_hmax    <= hmax;
            s2_row_odd <= s1_row_odd;
            s2_addr    <= s1_addr;
            s2_last    <= s1_last;
         end
      end
   end

   // Read address leads stage 2 by one cycle so the stored row is ready at the output stage.
   pool_line_buffer #(
      .DEPTH (COL_NUM / 2),
      .WIDTH (PIX_W),
      .AW    (AW)
   ) u_line_buffer (
      .clk     (clk),
      .wr_en   (s2_valid && !s2_row_odd),
      .wr_addr (s2_addr),
      .wr_data (s2_hmax),
      .rd_addr (s1_addr),
      .rd_data (lb_rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_out  <= 1'b0;
         dout       <= '0;
         frame_done <= 1'b0;
      end else begin
         valid_out  <= s2_valid && s2_row_odd;
         frame_done <= s2_valid && s2_row_odd && s2_last;
         if (s2_valid && s2_row_odd)
            dout <= pix_max(s2_hmax, lb_rd_data);
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_module_relu_pool.sv
// Scoreboard bench: two 4x4 instances (SHIFT=4 and SHIFT=0) driven with identical directed frames.
`default_nettype none
module tb_module_relu_pool;
   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               valid_in = 1'b0;
   logic signed [17:0] din = '0;
   logic signed [17:0] bias = '0;
   logic               valid_out4, frame_done4, valid_out0, frame_done0;
   logic [7:0]         dout4, dout0;

   typedef struct {int val; bit fd; int cyc;} exp_t;
   exp_t q4[$];
   exp_t q0[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] prev4 = '0, prev0 = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   module_relu_pool #(.COL_NUM(4), .ROW_NUM(4), .SHIFT(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .din(din), .bias(bias),
      .valid_out(valid_out4), .dout(dout4), .frame_done(frame_done4));
   module_relu_pool #(.COL_NUM(4), .ROW_NUM(4), .SHIFT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .din(din), .bias(bias),
      .valid_out(valid_out0), .dout(dout0), .frame_done(frame_done0));

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic mon(input int id, input logic v, input logic [7:0] d, input logic fd,
                      input logic [7:0] prev);
      exp_t e;
      if (!rst_n) return;
      if (v) begin
         if ((id == 4 && q4.size() == 0) || (id == 0 && q0.size() == 0)) begin
            chk($sformatf("dut%0d unexpected valid_out", id), 1, 0);
         end else begin
            e = (id == 4) ? q4.pop_front() : q0.pop_front();
            chk($sformatf("dut%0d dout", id), int'(d), e.val);
            chk($sformatf("dut%0d frame_done", id), int'(fd), int'(e.fd));
            chk($sformatf("dut%0d latency cycle", id), cyc, e.cyc);
         end
      end else begin
         chk($sformatf("dut%0d frame_done without valid", id), int'(fd), 0);
         chk($sformatf("dut%0d dout hold", id), int'(d), int'(prev));
      end
   endtask

   always @(negedge clk) begin
      mon(4, valid_out4, dout4, frame_done4, prev4);
      mon(0, valid_out0, dout0, frame_done0, prev0);
      prev4 = dout4;
      prev0 = dout0;
   end

   // Drives one 4x4 frame; abort_at >= 0 pulses reset after that beat and expects nothing.
   task automatic send_frame(input int d[16], input int b, input int e4[4], input int e0[4],
                             input int max_gap, input int abort_at);
      exp_t e;
      int   idx;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            idx      = r * 4 + c;
            valid_in = 1'b1;
            din      = 18'(d[idx]);
            bias     = (idx == 0) ? 18'(b) : 18'($urandom);
            if (abort_at < 0 && r[0] && c[0]) begin
               e.fd  = (idx == 15);
               e.cyc = cyc + 3;
               e.val = e4[(r / 2) * 2 + c / 2];
               q4.push_back(e);
               e.val = e0[(r / 2) * 2 + c / 2];
               q0.push_back(e);
            end
            @(negedge clk);
            valid_in = 1'b0;
            if (idx == abort_at) begin
               #2 rst_n = 1'b0;
               repeat (2) @(negedge clk);
               #2 rst_n = 1'b1;
               @(negedge clk);
               return;
            end
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
         end
      end
   endtask

   function automatic void fill(output int d[16], input int v);
      for (int i = 0; i < 16; i++) d[i] = v;
   endfunction

   initial begin
      int d[16];
      int ramp[16];
      for (int i = 0; i < 16; i++) ramp[i] = i;

      repeat (3) @(negedge clk);
      chk("reset valid_out4", int'(valid_out4), 0);
      chk("reset dout4", int'(dout4), 0);
      chk("reset frame_done4", int'(frame_done4), 0);
      chk("reset valid_out0", int'(valid_out0), 0);
      chk("reset dout0", int'(dout0), 0);
      #2 rst_n = 1'b1;
      @(negedge clk);

      fill(d, 100);
      send_frame(d, -20, '{5, 5, 5, 5}, '{80, 80, 80, 80}, 0, -1);
      fill(d, -50);
      send_frame(d, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 1, -1);
      fill(d, 5000);
      send_frame(d, 0, '{255, 255, 255, 255}, '{255, 255, 255, 255}, 0, -1);
      send_frame(ramp, 0, '{0, 0, 1, 1}, '{5, 7, 13, 15}, 0, -1);
      send_frame(ramp, 0, '{0, 0, 1, 1}, '{5, 7, 13, 15}, 5, -1);
      repeat (4) @(negedge clk);
      fill(d, 200);
      send_frame(d, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 0, 6);
      send_frame(ramp, 0, '{0, 0, 1, 1}, '{5, 7, 13, 15}, 0, -1);
      fill(d, 16);
      send_frame(d, 0, '{1, 1, 1, 1}, '{16, 16, 16, 16}, 0, -1);
      send_frame(d, 32, '{3, 3, 3, 3}, '{48, 48, 48, 48}, 0, -1);

      for (int i = 0; i < 20 && (q4.size() != 0 || q0.size() != 0); i++) @(negedge clk);
      chk("dut4 outstanding expectations", q4.size(), 0);
      chk("dut0 outstanding expectations", q0.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/module_relu_pool.md
MODULE_RELU_POOL -- requirements
Module: module_relu_pool

Interface
REQ-001 Parameter COL_NUM, 128, pixels per row; even, 4 to 1024.
REQ-002 Parameter ROW_NUM, 128, rows per frame; even, 4 to 1024.
REQ-003 Parameter SHIFT, 4, requantisation right-shift; 0 to 10.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low, ports clk and rst_n.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 valid_in  in  1  din carries one accumulated pixel this cycle; no backpressure.
REQ-008 din  in  18  signed final channel sum from the accumulation stage, raster order.
REQ-009 bias  in  18  signed per-map bias; sampled only on the frame's first beat.
REQ-010 valid_out  out  1  dout holds one pooled pixel.
REQ-011 dout  out  8  unsigned pooled activation.
REQ-012 frame_done  out  1  one-cycle pulse coincident with the frame's last valid_out.

Function
REQ-013 Beats SHALL be counted by col_cnt (0..COL_NUM-1) and row_cnt (0..ROW_NUM-1), advancing only on valid_in; col wraps to 0 with row increment; both wrap to 0 after beat (ROW_NUM-1, COL_NUM-1).
REQ-014 On the beat at (0,0), bias SHALL be latched into bias_r and used for the whole frame, including that beat.
REQ-015 Stage 1 (registered, 1 cycle): sum = din + bias, 19-bit signed, no overflow possible.
REQ-016 ReLU: sum < 0 gives 0.
REQ-017 Requantise: q = (sum + 2^(SHIFT-1)) >> SHIFT for SHIFT >= 1, q = sum for SHIFT = 0; q > 255 saturates to 255.
REQ-018 Stage 2: on odd col, hmax = max(q at even col, q at odd col); the even-col q is held in a register.
REQ-019 On even row, hmax SHALL be written to line buffer address col_cnt/2; no output.
REQ-020 On odd row, dout = max(hmax, line buffer[col_cnt/2]), with valid_out asserted.
REQ-021 Latency: valid_out SHALL assert exactly 2 clk cycles after the input beat at (odd row, odd col), independent of gaps in valid_in.
REQ-022 Pipeline stages SHALL carry their own valid bit; gaps between beats of any length are legal and SHALL NOT corrupt pairing or line-buffer contents.
REQ-023 Output count per frame SHALL be (COL_NUM/2)*(ROW_NUM/2).
REQ-024 frame_done SHALL pulse with the output of input beat (ROW_NUM-1, COL_NUM-1).
REQ-025 Back-to-back frames with no gap SHALL be supported; a new frame's bias latch SHALL NOT affect the previous frame's in-flight output.
REQ-026 dout SHALL hold its last value while valid_out is low.

Reset
REQ-027 On rst_n low: valid_out = 0, dout = 0, frame_done = 0, counters = 0, bias_r = 0, pipeline valid bits = 0.
REQ-028 Line buffer contents after reset are don't-care; the first frame's even rows overwrite them before any read.
REQ-029 Reset mid-frame SHALL discard the partial frame; the next beat after release is treated as (0,0).

Structure
REQ-030 Shared package SHALL hold ACC_W = 18, PIX_W = 8 and the saturation constant 255.
REQ-031 Line buffer SHALL be a sub-module pool_line_buffer: simple dual-port, depth COL_NUM/2, width PIX_W, 1-cycle synchronous read, address issued one cycle ahead.
REQ-032 The target RTL size is 150-300 lines.

Verification
REQ-033 COL_NUM=4, ROW_NUM=4, SHIFT=4, bias=-20, all din=100 -> 4 outputs of 5 ((80+8)>>4), frame_done with the 4th.
REQ-034 din=-50, bias=0 everywhere -> all outputs 0; din=5000, bias=0 -> all outputs 255 (313 saturated).
REQ-035 4x4 frame, SHIFT=0, bias=0, din = row*4+col -> outputs 5, 7, 13, 15 in that order, each 2 cycles after its (odd, odd) beat.
REQ-036 Same frame as REQ-035 with random 0-5 cycle gaps between beats -> identical outputs and latency measured from the triggering beat.
REQ-037 rst_n pulsed low after beat (1,2), then a full frame -> no output from the aborted frame; new frame outputs are correct.
REQ-038 Two back-to-back frames, bias 0 then 32, SHIFT=4, din=16 -> first frame outputs 1, second frame outputs 3.
